map_writer: RTL and testbench
=============================

// Module: map_writer
// PURPOSE
//   Write-side master for the world map RAM. It drives the map block's
//   write_addr/write_data/write_en port, which the raycast pipeline only reads.
//   - After reset, and on request, fills the 32x32x32 voxel map with flat terrain.
//   - Then accepts single-block place/break edits through a valid/ready handshake.
//   - Sits in the clk_ppl domain beside map; its outputs connect straight to map.
// PARAMETERS
//   AXIS_W     5   bits per map axis; map holds 2^(3*AXIS_W) blocks
//   ID_W       5   block id width
//   GROUND_H   8   terrain height: z < GROUND_H is solid
//   STONE_ID   3   id for z < GROUND_H-3
//   DIRT_ID    2   id for GROUND_H-3 <= z < GROUND_H-1
//   GRASS_ID   1   id for z == GROUND_H-1
//   AIR_ID     0   id for z >= GROUND_H
//   PROTECT_Z0 1   1: edits at z==0 are refused (floor is indestructible)
// PORTS
//   clk         in   1          map/pipeline clock
//   rst         in   1          asynchronous reset, active-high
//   init_start  in   1          pulse: refill whole map with terrain
//   init_busy   out  1          high while a fill is in progress
//   init_done   out  1          one-cycle pulse after the last fill write
//   edit_valid  in   1          edit request present
//   edit_ready  out  1          block can accept an edit this cycle
//   edit_x      in   AXIS_W     edit x coordinate
//   edit_y      in   AXIS_W     edit y coordinate
//   edit_z      in   AXIS_W     edit z coordinate (vertical)
//   edit_id     in   ID_W       new block id (AIR_ID = break)
//   edit_err    out  1          one-cycle pulse: accepted edit was refused
//   write_addr  out  3*AXIS_W   map address = {z, y, x}
//   write_data  out  ID_W       block id to write
//   write_en    out  1          map write strobe
// BEHAVIOUR
//   - Reset values: write_en=0, write_addr=0, write_data=0, init_busy=0,
//     init_done=0, edit_err=0; state=IDLE; fill counter=0; auto_init=1.
//   - All outputs except edit_ready are registered.
//     edit_ready = (state==IDLE) & ~init_start & ~auto_init (combinational).
//   - States:
//     - IDLE -> FILL when init_start | auto_init (clears auto_init, counter=0).
//     - FILL -> DONE after issuing address 2^(3*AXIS_W)-1.
//     - DONE -> IDLE unconditionally.
//   - FILL:
//     - write_en=1 every cycle, write_addr=counter, counter increments by 1.
//     - write_data follows the terrain rule on z=counter[3*AXIS_W-1:2*AXIS_W].
//     - Exactly 2^(3*AXIS_W) consecutive writes (32768 with defaults).
//     - init_busy=1 from the first fill write to the last, inclusive.
//   - DONE: write_en=0, init_busy=0, init_done=1 for this one cycle.
//   - init_start during FILL/DONE is ignored; no restart and no queueing.
//   - Edit:
//     - Accepted on edit_valid & edit_ready.
//     - Next cycle: write_en=1, write_addr={edit_z,edit_y,edit_x},
//       write_data=edit_id. Latency 1 cycle; throughput 1 edit/cycle.
//     - If PROTECT_Z0 & edit_z==0, the edit is still accepted but write_en
//       stays 0, and edit_err=1 the next cycle instead.
//   - init_start and edit_valid in the same IDLE cycle: init wins, the edit is
//     not accepted (edit_ready=0) and is held by the requester.
//   - Width rules:
//     - Counter is 3*AXIS_W+1 bits; the top bit is not used as an address.
//     - Terrain thresholds are compared as unsigned AXIS_W values.
//   - rst mid-FILL: write_en drops asynchronously, and a fresh full fill restarts
//     from address 0 after release (auto_init).
// TESTING
//   - Release rst -> write_en high 32768 consecutive cycles, addr 0..32767 in
//     order; init_done pulses once, on the following cycle.
//   - Fill data checks:
//     - addr {z=7,y=3,x=4} -> data 1
//     - z=6 -> 2
//     - z=4 -> 3
//     - z=8 -> 0
//     - z=31 -> 0
//   - Edit x=5,y=6,z=9,id=4, valid held one cycle while idle -> next cycle
//     write_en=1, addr=0x24C5, data=4; no further writes.
//   - Edit z=0 with PROTECT_Z0=1 -> no write_en; edit_err pulses one cycle;
//     edit_ready stays high.
//   - init_start and edit_valid together -> edit not accepted, fill starts;
//     edit_ready low until the cycle after init_done; then the held edit is
//     written.
//   - Assert rst at fill address 1000 -> write_en=0 immediately; after release
//     the fill restarts from addr 0 and completes all 32768 writes.

Source files
------------

// File: rtl/map_writer.sv
// Write-side master for the voxel map RAM: fills the map with flat terrain
// after reset or on request, then applies single-block edits.
module map_writer #(
    parameter int unsigned AXIS_W     = 5,
    parameter int unsigned ID_W       = 5,
    parameter int unsigned GROUND_H   = 8,
    parameter int unsigned STONE_ID   = 3,
    parameter int unsigned DIRT_ID    = 2,
    parameter int unsigned GRASS_ID   = 1,
    parameter int unsigned AIR_ID     = 0,
    parameter int unsigned PROTECT_Z0 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    input  logic                  edit_valid,
    output logic                  edit_ready,
    input  logic [AXIS_W-1:0]     edit_x,
    input  logic [AXIS_W-1:0]     edit_y,
    input  logic [AXIS_W-1:0]     edit_z,
    input  logic [ID_W-1:0]       edit_id,
    output logic                  edit_err,
    output logic [3*AXIS_W-1:0]   write_addr,
    output logic [ID_W-1:0]       write_data,
    output logic                  write_en
);

    localparam int unsigned ADDR_W = 3 * AXIS_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                auto_init_q;
    logic                write_en_q;
    logic [ADDR_W-1:0]   write_addr_q;
    logic [ID_W-1:0]     write_data_q;
    logic                init_busy_q;
    logic                init_done_q;
    logic                edit_err_q;
    logic                edit_fire;
    logic                edit_refused;

    // Flat terrain: stone, two layers of dirt, one of grass, air above.
    function automatic logic [ID_W-1:0] terrain_id(input logic [AXIS_W-1:0] z);
        if (z < AXIS_W'(GROUND_H - 3))      return ID_W'(STONE_ID);
        else if (z < AXIS_W'(GROUND_H - 1)) return ID_W'(DIRT_ID);
        else if (z == AXIS_W'(GROUND_H - 1)) return ID_W'(GRASS_ID);
        else                                 return ID_W'(AIR_ID);
    endfunction

    assign edit_ready   = (state_q == S_IDLE) & ~init_start & ~auto_init_q;
    assign edit_fire    = edit_valid & edit_ready;
    assign edit_refused = (PROTECT_Z0 != 0) && (edit_z == '0);

    // The first fill write is issued on the IDLE->FILL transition so that the
    // FILL state spans exactly the write cycles; cnt_q's top bit marks the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            auto_init_q  <= 1'b1;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            init_busy_q  <= 1'b0;
            init_done_q  <= 1'b0;
            edit_err_q   <= 1'b0;
        end else begin
            write_en_q  <= 1'b0;
            init_done_q <= 1'b0;
            edit_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (init_start || auto_init_q) begin
                        state_q      <= S_FILL;
                        auto_init_q  <= 1'b0;
                        write_en_q   <= 1'b1;
                        write_addr_q <= '0;
                        write_data_q <= terrain_id('0);
                        init_busy_q  <= 1'b1;
                        cnt_q        <= CNT_W'(1);
                    end else if (edit_fire) begin
                        if (edit_refused) begin
                            edit_err_q <= 1'b1;
                        end else begin
                            write_en_q   <= 1'b1;
                            write_addr_q <= {edit_z, edit_y, edit_x};
                            write_data_q <= edit_id;
                        end
                    end
                end
                S_FILL: begin
                    if (cnt_q[ADDR_W]) begin
                        state_q     <= S_DONE;
                        init_busy_q <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        write_en_q   <= 1'b1;
                        write_addr_q <= cnt_q[ADDR_W-1:0];
                        write_data_q <= terrain_id(cnt_q[ADDR_W-1:2*AXIS_W]);
                        cnt_q        <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    init_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign init_busy  = init_busy_q;
    assign init_done  = init_done_q;
    assign edit_err   = edit_err_q;

endmodule

// File: tb/tb_map_writer.sv
// Scoreboard bench for map_writer: stimulus pushes expected map writes,
// refusals and fill completions; a negedge monitor pops and compares.
module tb_map_writer;

    localparam int NBLK = 32768;
    localparam logic [1:0] K_W = 2'd0;
    localparam logic [1:0] K_E = 2'd1;
    localparam logic [1:0] K_D = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_start;
    logic        init_busy;
    logic        init_done;
    logic        edit_valid;
    logic        edit_ready;
    logic [4:0]  edit_x, edit_y, edit_z, edit_id;
    logic        edit_err;
    logic [14:0] write_addr;
    logic [4:0]  write_data;
    logic        write_en;

    typedef struct packed {
        logic [1:0]  kind;
        logic [14:0] addr;
        logic [4:0]  data;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int spot_a[5] = '{7268, 6484, 5119, 8192, 31749};
    int spot_d[5] = '{1, 2, 3, 0, 0};

    map_writer dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .edit_valid (edit_valid),
        .edit_ready (edit_ready),
        .edit_x     (edit_x),
        .edit_y     (edit_y),
        .edit_z     (edit_z),
        .edit_id    (edit_id),
        .edit_err   (edit_err),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] k, input int a, input int d, input logic b);
        exp_t e;
        e.kind = k;
        e.addr = 15'(a);
        e.data = 5'(d);
        e.busy = b;
        return e;
    endfunction

    // Terrain by height band: ground is 8 blocks thick.
    function automatic int model_terrain(input int z);
        if (z >= 8)  return 0;
        if (z == 7)  return 1;
        if (z >= 5)  return 2;
        return 3;
    endfunction

    task automatic push_fill();
        for (int i = 0; i < NBLK; i++)
            sb.push_back(mk(K_W, i, model_terrain(i / 1024), 1'b1));
        sb.push_back(mk(K_D, 0, 0, 1'b0));
    endtask

    // Monitor: every DUT event must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (write_en) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected none", write_addr, write_data);
                end else begin
                    e = sb.pop_front();
                    check("wr_kind", 0, int'(e.kind));
                    check("wr_addr", int'(write_addr), int'(e.addr));
                    check("wr_data", int'(write_data), int'(e.data));
                    check("wr_busy", int'(init_busy), int'(e.busy));
                end
                for (int s = 0; s < 5; s++)
                    if (init_busy && int'(write_addr) == spot_a[s])
                        check("fill_spot", int'(write_data), spot_d[s]);
            end
            if (edit_err) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_err: got edit_err 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    check("err_kind", int'(K_E), int'(e.kind));
                end
            end
            if (init_done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got init_done 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    check("done_kind", int'(K_D), int'(e.kind));
                    check("done_busy", int'(init_busy), 0);
                end
            end
        end
    end

    task automatic drain(input string name);
        bit ok = 0;
        for (int n = 0; n < 40000; n++) begin
            @(posedge clk);
            if (sb.size() == 0) begin ok = 1; break; end
        end
        check(name, int'(ok), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Present an edit and hold it until accepted; returns at accept edge + 1.
    task automatic do_edit(input int x, input int y, input int z, input int id);
        bit ok = 0;
        edit_valid = 1'b1;
        edit_x = 5'(x); edit_y = 5'(y); edit_z = 5'(z); edit_id = 5'(id);
        for (int n = 0; n < 40000; n++) begin
            @(negedge clk);
            if (edit_ready) begin ok = 1; break; end
        end
        check("edit_accept", int'(ok), 1);
        if (z == 0) sb.push_back(mk(K_E, 0, 0, 1'b0));
        else        sb.push_back(mk(K_W, z * 1024 + y * 32 + x, id, 1'b0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #(2_000_000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        bit pd;
        rst = 1'b1; init_start = 1'b0; edit_valid = 1'b0;
        edit_x = '0; edit_y = '0; edit_z = '0; edit_id = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",    int'(write_en), 0);
        check("rst_addr",  int'(write_addr), 0);
        check("rst_data",  int'(write_data), 0);
        check("rst_busy",  int'(init_busy), 0);
        check("rst_done",  int'(init_done), 0);
        check("rst_err",   int'(edit_err), 0);
        check("rst_ready", int'(edit_ready), 0);

        // Auto fill after reset, interrupted by reset at address 1000.
        rst = 1'b0;
        push_fill();
        found = 0;
        for (int n = 0; n < 5000; n++) begin
            @(posedge clk); #2;
            if (write_en && write_addr == 15'd1000) begin found = 1; break; end
        end
        check("reach_1000", int'(found), 1);
        rst = 1'b1;
        #1;
        check("rst_async_we", int'(write_en), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_fill();
        drain("fill_after_rst");
        check("ready_after_fill", int'(edit_ready), 1);

        // Single edit: {z=9,y=6,x=5} id 4.
        do_edit(5, 6, 9, 4);
        edit_valid = 1'b0;
        check("edit_we",   int'(write_en), 1);
        check("edit_addr", int'(write_addr), 'h24C5);
        check("edit_data", int'(write_data), 4);
        @(posedge clk); #1;
        check("edit_once", int'(write_en), 0);

        // Floor edit is refused.
        do_edit(3, 3, 0, 7);
        edit_valid = 1'b0;
        check("z0_we",    int'(write_en), 0);
        check("z0_err",   int'(edit_err), 1);
        check("z0_ready", int'(edit_ready), 1);
        @(posedge clk); #1;
        check("z0_err_pulse", int'(edit_err), 0);

        // Random back-to-back edits.
        for (int i = 0; i < 24; i++)
            do_edit($urandom_range(31), $urandom_range(31),
                    ($urandom_range(3) == 0) ? 0 : $urandom_range(31),
                    $urandom_range(31));
        edit_valid = 1'b0;
        drain("rand_edits");

        // Init and edit together: init wins, edit waits for the fill.
        init_start = 1'b1;
        edit_valid = 1'b1;
        edit_x = 5'd1; edit_y = 5'd2; edit_z = 5'd20; edit_id = 5'd9;
        #1;
        check("ready_vs_init", int'(edit_ready), 0);
        push_fill();
        @(posedge clk); #1;
        init_start = 1'b0;
        found = 0;
        pd = 0;
        for (int n = 0; n < 40000; n++) begin
            @(negedge clk);
            if (edit_ready) begin found = 1; break; end
            pd = init_done;
            if (n == 100) init_start = 1'b1;
            if (n == 101) init_start = 1'b0;
        end
        check("held_edit_ready", int'(found), 1);
        check("ready_after_done", int'(pd), 1);
        sb.push_back(mk(K_W, 20 * 1024 + 2 * 32 + 1, 9, 1'b0));
        @(posedge clk); #1;
        edit_valid = 1'b0;
        drain("init_edit");
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
